hit_sample_fifo: RTL and testbench
==================================

# hit_sample_fifo

Downstream stage of `rast`. It captures the four-lane sample output (`hit_R18S`, `color_R18U`, `hit_valid_R18H`) every cycle and packs the valid lanes in ascending lane order into a circular buffer. It then presents the samples one per cycle on a valid/ready stream toward the framebuffer/z-buffer writer. `rast` has no stall input, so the block never back-pressures upstream. If a cycle's group of samples does not fit, it drops the whole group and reports the loss through a sticky overflow flag and a drop counter.

## Interface
- `SIGFIG`, 24, bits per coordinate/color component
- `AXIS`, 3, coordinates per sample (x,y,z)
- `COLORS`, 3, color channels per sample
- `LANES`, 4, samples per input cycle
- `DEPTH`, 32, buffer entries; power of two, ≥ 2*LANES
- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-high
- `hit_R18S`  in  [LANES-1:0][AXIS-1:0] x SIGFIG signed  sample positions
- `color_R18U`  in  [LANES-1:0][COLORS-1:0] x SIGFIG unsigned  sample colors
- `hit_valid_R18H`  in  [LANES-1:0] x 1  per-lane hit valid
- `out_valid`  out  1  head entry available
- `out_ready`  in  1  consumer accepts head this cycle
- `out_hit`  out  [AXIS-1:0] x SIGFIG signed  head position
- `out_color`  out  [COLORS-1:0] x SIGFIG unsigned  head color
- `count`  out  $clog2(DEPTH)+1  occupied entries
- `overflow`  out  1  sticky: at least one group dropped since reset
- `drop_cnt`  out  16  dropped groups, saturating at 16'hFFFF
- `hits_total`  out  32  samples accepted into buffer, wraps modulo 2^32

## Operation
- Storage: register array of DEPTH entries {hit, color}, `wr_ptr`/`rd_ptr` of $clog2(DEPTH) bits, plus `count`. Pointers wrap naturally at DEPTH.
- Per cycle, `n` = popcount(`hit_valid_R18H`), range 0..LANES.
- Compaction: the k-th valid lane in ascending index goes to entry `wr_ptr+k` (mod DEPTH). Example: valid=4'b1010 writes lane1 to wr_ptr and lane3 to wr_ptr+1.
- Push admission: accept iff `n` ≤ DEPTH − `count`, using the registered `count`. A pop in the same cycle does not free space for that cycle's push.
- Accept: write `n` entries, `wr_ptr += n`, `hits_total += n`.
- Reject (`n`>0 and no room): write nothing. Set `overflow`=1 and stays set until reset. `drop_cnt` += 1, saturating. The group is all-or-nothing; it is never partially written.
- Pop: when `out_valid && out_ready`, `rd_ptr += 1`.
- Occupancy: `count` next = `count` + (accepted ? n : 0) − pop. Simultaneous push and pop are allowed.
- `out_valid` = (`count` != 0). `out_hit`/`out_color` = entry[`rd_ptr`] (combinational read of the register array). They are don't-care when `out_valid`=0, but must not be X after reset.
- `out_ready` while `out_valid`=0 has no effect.

## Timing
- Reset, asynchronous: `wr_ptr`, `rd_ptr`, `count`, `overflow`, `drop_cnt`, `hits_total` = 0. `out_valid`=0, and all storage entries are cleared to 0, so `out_hit`/`out_color` = 0.
- Reset asserted mid-stream discards all buffered samples immediately, with no clock edge required. The first push after deassertion lands at entry 0.
- Latency: samples presented at edge t (into an empty buffer) appear with `out_valid`=1 after edge t. The first is poppable in the cycle following capture.
- Throughput: input up to LANES samples/cycle, output 1 sample/cycle.
- Full boundary: at `count`=DEPTH, any `n`≥1 is rejected even with a simultaneous pop. `n`=0 is never a drop.
- Wrap: a group straddling index DEPTH−1→0 is written contiguously modulo DEPTH.

## Test plan
- Reset then single-lane: valid=4'b0001 with hit=(5,6,7), color=(1,2,3) for one cycle, `out_ready`=1. Next cycle: `out_valid`=1, `out_hit`=(5,6,7), `out_color`=(1,2,3), `count`=1. The cycle after: `count`=0 and `hits_total`=1.
- Compaction order: valid=4'b1010 with lane1 x=11, lane3 x=33, `out_ready`=0. Result: `count`=2; popping yields x=11, then x=33.
- Fill and drop: `out_ready`=0, valid=4'b1111 for 8 cycles gives `count`=32. The 9th cycle (4'b1111) is rejected: `overflow`=1, `drop_cnt`=1, `count`=32. A 10th cycle with valid=0 leaves `drop_cnt`=1.
- No same-cycle credit: at `count`=31 apply valid=4'b0011 with `out_ready`=1. The group is dropped (`drop_cnt`+1) and `count`=30.
- Wrap: push/pop so that `wr_ptr`=30, then push 4'b1111 with x=100..103. Entries land at 30,31,0,1; the pop sequence is 100,101,102,103 and `wr_ptr`=2.
- Async reset mid-stream: with `count`=7 and `overflow`=1, assert `rst` between clock edges. Immediately `count`=0, `out_valid`=0, `overflow`=0, `drop_cnt`=0. A push after release is read back correctly.

Source files
------------

// File: rtl/hit_sample_fifo.sv
// ---------------------------------------------------------------------------
// hit_sample_fifo
//   Captures the four-lane sample output of the rasterizer every cycle. Valid
//   lanes are packed in ascending lane order into a circular buffer. The block
//   then streams them out one per cycle on a valid/ready interface.
//   The upstream stage cannot stall. A group that does not fit is dropped
//   whole, and the loss is reported by a sticky flag and a drop counter.
//
// Ports
//   clk, rst          clock; asynchronous active-high reset
//   hit_R18S          per-lane signed positions (x,y,z)
//   color_R18U        per-lane unsigned colors
//   hit_valid_R18H    per-lane valid
//   out_valid         buffer is non-empty; out_hit/out_color hold the head
//   out_ready         consumer takes the head this cycle
//   out_hit/out_color head entry (combinational read)
//   count             occupied entries (0..DEPTH)
//   overflow          sticky: a group has been dropped since reset
//   drop_cnt          dropped groups, saturating
//   hits_total        samples accepted, wrapping
// ---------------------------------------------------------------------------
module hit_sample_fifo #(
  parameter int SIGFIG = 24,
  parameter int AXIS   = 3,
  parameter int COLORS = 3,
  parameter int LANES  = 4,
  parameter int DEPTH  = 32
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic signed [LANES-1:0][AXIS-1:0][SIGFIG-1:0] hit_R18S,
  input  logic [LANES-1:0][COLORS-1:0][SIGFIG-1:0]      color_R18U,
  input  logic [LANES-1:0]                              hit_valid_R18H,
  output logic                                          out_valid,
  input  logic                                          out_ready,
  output logic signed [AXIS-1:0][SIGFIG-1:0]            out_hit,
  output logic [COLORS-1:0][SIGFIG-1:0]                 out_color,
  output logic [$clog2(DEPTH):0]                        count,
  output logic                                          overflow,
  output logic [15:0]                                   drop_cnt,
  output logic [31:0]                                   hits_total
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int NW = $clog2(LANES + 1);

  typedef logic [AXIS-1:0][SIGFIG-1:0]   hit_t;
  typedef logic [COLORS-1:0][SIGFIG-1:0] color_t;

  hit_t          mem_hit   [DEPTH];
  color_t        mem_color [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  // Each lane's offset from wr_ptr is the number of valid lanes below it.
  logic [NW-1:0] lane_off [LANES];
  logic [NW-1:0] n;
  logic [CW-1:0] room;
  logic          accept;
  logic          drop;
  logic          pop;

  // NOTE: the running sum uses blocking assignments on purpose. Each lane
  // must see the partial count from the lanes before it within the same
  // evaluation. n is given a value before the loop so no latch is inferred.
  always_comb begin
    n = '0;
    for (int l = 0; l < LANES; l++) begin
      lane_off[l] = n;
      n           = n + NW'(hit_valid_R18H[l]);
    end
  end

  // Admission uses the registered count only. A same-cycle pop gives no credit.
  assign room   = CW'(DEPTH) - count;
  assign accept = CW'(n) <= room;
  assign drop   = (n != '0) && !accept;
  assign pop    = out_valid && out_ready;

  // NOTE: the storage array is reset as well. After reset (including a
  // mid-stream reset) the head read must return 0, never stale data or X.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_hit[i]   <= '0;
        mem_color[i] <= '0;
      end
    end else if (accept) begin
      for (int l = 0; l < LANES; l++) begin
        if (hit_valid_R18H[l]) begin
          mem_hit[wr_ptr + PW'(lane_off[l])]   <= hit_R18S[l];
          mem_color[wr_ptr + PW'(lane_off[l])] <= color_R18U[l];
        end
      end
    end
  end

  // NOTE: all state is updated with non-blocking assignments, so every
  // update reads the pre-edge values of count and the pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      drop_cnt   <= '0;
      hits_total <= '0;
    end else begin
      if (accept) begin
        wr_ptr     <= wr_ptr + PW'(n);
        hits_total <= hits_total + 32'(n);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count + (accept ? CW'(n) : CW'(0)) - CW'(pop);
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != 16'hFFFF) begin
          drop_cnt <= drop_cnt + 16'd1;
        end
      end
    end
  end

  assign out_valid = (count != '0);
  assign out_hit   = mem_hit[rd_ptr];
  assign out_color = mem_color[rd_ptr];

endmodule

// File: tb/tb_hit_sample_fifo.sv
// ---------------------------------------------------------------------------
// tb_hit_sample_fifo
//   Scoreboard bench for hit_sample_fifo. The driver issues directed and
//   random groups. A behavioural model (a sample queue plus an occupancy
//   integer) decides whether each group is accepted and enqueues the expected
//   samples. The monitor runs on the falling edge. It pops and compares
//   whenever the DUT hands over a sample, and checks the status outputs.
// ---------------------------------------------------------------------------
module tb_hit_sample_fifo;

  localparam int SIGFIG = 24;
  localparam int AXIS   = 3;
  localparam int COLORS = 3;
  localparam int LANES  = 4;
  localparam int DEPTH  = 32;

  typedef struct packed {
    logic [AXIS*SIGFIG-1:0]   hit;
    logic [COLORS*SIGFIG-1:0] color;
  } sample_t;

  logic                                          clk = 1'b0;
  logic                                          rst = 1'b1;
  logic signed [LANES-1:0][AXIS-1:0][SIGFIG-1:0] hit_R18S;
  logic [LANES-1:0][COLORS-1:0][SIGFIG-1:0]      color_R18U;
  logic [LANES-1:0]                              hit_valid_R18H;
  logic                                          out_valid;
  logic                                          out_ready;
  logic signed [AXIS-1:0][SIGFIG-1:0]            out_hit;
  logic [COLORS-1:0][SIGFIG-1:0]                 out_color;
  logic [$clog2(DEPTH):0]                        count;
  logic                                          overflow;
  logic [15:0]                                   drop_cnt;
  logic [31:0]                                   hits_total;

  hit_sample_fifo #(
    .SIGFIG(SIGFIG), .AXIS(AXIS), .COLORS(COLORS), .LANES(LANES), .DEPTH(DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .hit_R18S       (hit_R18S),
    .color_R18U     (color_R18U),
    .hit_valid_R18H (hit_valid_R18H),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_hit        (out_hit),
    .out_color      (out_color),
    .count          (count),
    .overflow       (overflow),
    .drop_cnt       (drop_cnt),
    .hits_total     (hits_total)
  );

  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  bit          mon_en   = 1'b0;
  sample_t     exp_q[$];
  int          m_count;
  int          m_drop;
  int          m_wr;
  bit          m_ovf;
  logic [31:0] m_hits;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_count = 0;
    m_drop  = 0;
    m_wr    = 0;
    m_ovf   = 1'b0;
    m_hits  = '0;
  endtask

  // Reference behaviour for one clock edge, using the inputs that were applied.
  task automatic model_step(input logic [LANES-1:0] v, input logic rdy);
    int n;
    bit do_pop;
    n      = $countones(v);
    do_pop = (m_count > 0) && rdy;
    if (n <= DEPTH - m_count) begin
      for (int l = 0; l < LANES; l++)
        if (v[l]) exp_q.push_back({hit_R18S[l], color_R18U[l]});
      m_count += n;
      m_hits  += 32'(n);
      m_wr     = (m_wr + n) % DEPTH;
    end else begin
      m_ovf = 1'b1;
      if (m_drop < 65535) m_drop++;
    end
    if (do_pop) m_count--;
  endtask

  // Apply one cycle of input, let the edge happen, and advance the model.
  task automatic cycle(input logic [LANES-1:0] v, input logic rdy);
    hit_valid_R18H = v;
    out_ready      = rdy;
    @(posedge clk);
    model_step(v, rdy);
    #1;
  endtask

  task automatic rand_data();
    for (int l = 0; l < LANES; l++) begin
      for (int a = 0; a < AXIS; a++)   hit_R18S[l][a]   = SIGFIG'($urandom);
      for (int c = 0; c < COLORS; c++) color_R18U[l][c] = SIGFIG'($urandom);
    end
  endtask

  task automatic drain();
    int budget;
    budget = 4 * DEPTH;
    while (m_count > 0 && budget > 0) begin
      cycle('0, 1'b1);
      budget--;
    end
    check("drain_budget", 72'(m_count), 72'd0);
  endtask

  // Reset applied between clock edges. The DUT must clear without an edge.
  task automatic async_reset();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    @(posedge clk);
    #3;
    hit_valid_R18H = '0;
    out_ready      = 1'b0;
    rst            = 1'b0;
  endtask

  // Monitor: the scoreboard pop and status comparison, once per cycle.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      check("count",      72'(count),      72'(m_count));
      check("out_valid",  72'(out_valid),  72'(m_count != 0));
      check("overflow",   72'(overflow),   72'(m_ovf));
      check("drop_cnt",   72'(drop_cnt),   72'(m_drop));
      check("hits_total", 72'(hits_total), 72'(m_hits));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL pop_unexpected act=out_valid exp=no_sample @%0t", $time);
        end else begin
          sample_t s;
          s = exp_q.pop_front();
          check("pop_hit",   72'(out_hit),   s.hit);
          check("pop_color", 72'(out_color), s.color);
        end
      end
    end
  end

  initial begin
    hit_R18S       = '0;
    color_R18U     = '0;
    hit_valid_R18H = '0;
    out_ready      = 1'b0;
    model_reset();

    // Reset state
    #12;
    check("rst_count",     72'(count),     72'd0);
    check("rst_valid",     72'(out_valid), 72'd0);
    check("rst_out_hit",   72'(out_hit),   72'd0);
    check("rst_out_color", 72'(out_color), 72'd0);
    check("rst_overflow",  72'(overflow),  72'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    // Single lane
    hit_R18S[0]   = {24'd7, 24'd6, 24'd5};
    color_R18U[0] = {24'd3, 24'd2, 24'd1};
    cycle(4'b0001, 1'b1);
    check("single_valid", 72'(out_valid), 72'd1);
    check("single_hit",   72'(out_hit),   {24'd7, 24'd6, 24'd5});
    check("single_color", 72'(out_color), {24'd3, 24'd2, 24'd1});
    check("single_count", 72'(count),     72'd1);
    cycle(4'b0000, 1'b1);
    check("single_count2", 72'(count),      72'd0);
    check("single_total",  72'(hits_total), 72'd1);

    // Compaction order
    rand_data();
    hit_R18S[1][0] = 24'd11;
    hit_R18S[3][0] = 24'd33;
    cycle(4'b1010, 1'b0);
    check("compact_count", 72'(count),      72'd2);
    check("compact_first", 72'(out_hit[0]), 72'd11);
    cycle(4'b0000, 1'b1);
    check("compact_second", 72'(out_hit[0]), 72'd33);
    drain();

    // Fill and drop
    async_reset();
    for (int i = 0; i < 8; i++) begin
      rand_data();
      cycle(4'b1111, 1'b0);
    end
    check("fill_count", 72'(count), 72'd32);
    rand_data();
    cycle(4'b1111, 1'b0);
    check("full_overflow", 72'(overflow), 72'd1);
    check("full_drop",     72'(drop_cnt), 72'd1);
    check("full_count",    72'(count),    72'd32);
    cycle(4'b0000, 1'b0);
    check("full_idle_drop", 72'(drop_cnt), 72'd1);

    // Async reset mid-stream: reach count=7 with overflow set
    for (int i = 0; i < 25; i++) cycle(4'b0000, 1'b1);
    check("pre_rst_count", 72'(count), 72'd7);
    #2;
    rst = 1'b1;
    #1;
    check("arst_count",    72'(count),     72'd0);
    check("arst_valid",    72'(out_valid), 72'd0);
    check("arst_overflow", 72'(overflow),  72'd0);
    check("arst_drop",     72'(drop_cnt),  72'd0);
    check("arst_out_hit",  72'(out_hit),   72'd0);
    model_reset();
    @(posedge clk);
    #3;
    hit_valid_R18H = '0;
    out_ready      = 1'b0;
    rst            = 1'b0;
    rand_data();
    hit_R18S[2] = {24'd42, 24'd41, 24'd40};
    cycle(4'b0100, 1'b0);
    check("arst_push_hit", 72'(out_hit),    {24'd42, 24'd41, 24'd40});
    check("arst_wr_ptr",   72'(dut.wr_ptr), 72'd1);
    drain();

    // No same-cycle credit at count=31
    async_reset();
    for (int i = 0; i < 7; i++) begin
      rand_data();
      cycle(4'b1111, 1'b0);
    end
    rand_data();
    cycle(4'b0111, 1'b0);
    check("credit_count31", 72'(count), 72'd31);
    rand_data();
    cycle(4'b0011, 1'b1);
    check("credit_drop",  72'(drop_cnt), 72'd1);
    check("credit_count", 72'(count),    72'd30);
    drain();

    // Wrap across DEPTH-1 -> 0
    async_reset();
    for (int i = 0; i < 7; i++) begin
      rand_data();
      cycle(4'b1111, 1'b0);
    end
    rand_data();
    cycle(4'b0011, 1'b0);
    drain();
    check("wrap_wr30", 72'(dut.wr_ptr), 72'd30);
    rand_data();
    for (int l = 0; l < LANES; l++) hit_R18S[l][0] = SIGFIG'(100 + l);
    cycle(4'b1111, 1'b0);
    check("wrap_wr2",   72'(dut.wr_ptr), 72'd2);
    check("wrap_head",  72'(out_hit[0]), 72'd100);
    cycle(4'b0000, 1'b1);
    check("wrap_next",  72'(out_hit[0]), 72'd101);
    cycle(4'b0000, 1'b1);
    check("wrap_third", 72'(out_hit[0]), 72'd102);
    cycle(4'b0000, 1'b1);
    check("wrap_last",  72'(out_hit[0]), 72'd103);
    drain();

    // Random traffic with phases of heavy and light draining
    async_reset();
    for (int i = 0; i < 3000; i++) begin
      logic [LANES-1:0] v;
      logic             r;
      rand_data();
      v = LANES'($urandom);
      if ((i / 200) % 2 == 0) r = ($urandom_range(0, 3) == 0);
      else                    r = ($urandom_range(0, 3) != 0);
      cycle(v, r);
    end
    drain();
    check("final_queue_empty", 72'(exp_q.size()), 72'd0);

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
